// File: rtl/if_id_queue_pkg.sv
// Shared RISC-V definitions used by the fetch/decode boundary: opcode constants,
// the buffered queue entry layout and the control-flow opcode classifier.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] inst;
        logic                    is_ctrl;
    } ifq_entry_t;

    // True for opcodes that may redirect the pc (jumps and conditional branches).
    function automatic logic is_ctrl_opcode(input logic [6:0] opc);
        logic res;
        case (opc)
            OPC_JAL:    res = 1'b1;
            OPC_JALR:   res = 1'b1;
            OPC_BRANCH: res = 1'b1;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue. The queue uses the
// slave modport; the fetch/decode side (or a bench) uses master.
interface if_id_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                     if_valid;
    logic [XLEN-1:0]          if_pc;
    logic [XLEN-1:0]          if_inst;
    logic                     if_ready;
    logic                     id_valid;
    logic [XLEN-1:0]          id_pc;
    logic [XLEN-1:0]          id_inst;
    logic                     id_is_ctrl;
    logic                     id_ready;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output if_valid, if_pc, if_inst, id_ready, flush,
        input  if_ready, id_valid, id_pc, id_inst, id_is_ctrl, count
    );

    modport slave (
        input  if_valid, if_pc, if_inst, id_ready, flush,
        output if_ready, id_valid, id_pc, id_inst, id_is_ctrl, count
    );

endinterface

// File: rtl/ifq_predecode.sv
// Combinational predecode: flags instructions whose opcode is JAL, JALR or BRANCH.
module ifq_predecode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_ctrl
);

    assign is_ctrl = is_ctrl_opcode(opcode);

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of {pc, inst, is_ctrl}
// with one-cycle flush. Optional zero-latency empty-queue bypass: define IFQ_BYPASS_EN.
module if_id_queue
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_mem_r   [DEPTH];
    logic [XLEN-1:0]  inst_mem_r [DEPTH];
    logic [DEPTH-1:0] ctrl_mem_r;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic empty_s;
    logic full_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;
    logic is_ctrl_s;

    ifq_predecode u_predecode (
        .opcode  (q.if_inst[6:0]),
        .is_ctrl (is_ctrl_s)
    );

    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign q.if_ready = ~full_s;
    assign q.count    = count_r;

    // Empty-queue bypass qualifier; stays low when the feature is compiled out.
    always_comb begin
        bypass_s = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (empty_s && q.if_valid && !q.flush) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
`endif
    end

    // A bypassed entry consumed the same cycle is never written into storage.
    assign push_s = q.if_valid && !full_s && !(bypass_s && q.id_ready);
    assign pop_s  = !empty_s && q.id_ready;

    // Head presentation: stored head, live bypass, or masked to zero.
    always_comb begin
        q.id_valid   = 1'b0;
        q.id_pc      = {XLEN{1'b0}};
        q.id_inst    = {XLEN{1'b0}};
        q.id_is_ctrl = 1'b0;
        if (!empty_s) begin
            q.id_valid   = 1'b1;
            q.id_pc      = pc_mem_r[rd_ptr_r];
            q.id_inst    = inst_mem_r[rd_ptr_r];
            q.id_is_ctrl = ctrl_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            q.id_valid   = 1'b1;
            q.id_pc      = q.if_pc;
            q.id_inst    = q.if_inst;
            q.id_is_ctrl = is_ctrl_s;
        end else begin
            q.id_valid   = 1'b0;
        end
    end

    // Pointer and occupancy update; reset outranks flush, flush outranks push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (q.flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; predecode result is captured alongside the instruction.
    always_ff @(posedge clk) begin
        if (push_s && !q.flush && !rst) begin
            pc_mem_r[wr_ptr_r]   <= q.if_pc;
            inst_mem_r[wr_ptr_r] <= q.if_inst;
            ctrl_mem_r[wr_ptr_r] <= is_ctrl_s;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, a few hand sequences, and a random
// run scored against a queue-based reference model.
module tb_if_id_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_id_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) ifc ();

    if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (ifc)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdy;
        logic        fl;
        logic        e_valid;
        logic        e_ready;
        logic [2:0]  e_cnt;
        logic [31:0] e_pc;
        logic        e_ctrl;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t vecs[$];
    ent_t model[$];

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_8067;
    localparam logic [31:0] BEQ  = 32'h0000_0463;

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] pc,
                                input logic [31:0] inst, input logic rdy, input logic fl,
                                input logic ev, input logic er, input logic [2:0] ec,
                                input logic [31:0] epc, input logic ectl);
        vec_t t;
        t.rst = r; t.v = v; t.pc = pc; t.inst = inst; t.rdy = rdy; t.fl = fl;
        t.e_valid = ev; t.e_ready = er; t.e_cnt = ec; t.e_pc = epc; t.e_ctrl = ectl;
        return t;
    endfunction

    function automatic logic ref_ctrl(input logic [31:0] inst);
        logic [6:0] opc;
        opc = inst[6:0];
        return (opc == 7'h6F) || (opc == 7'h67) || (opc == 7'h63);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0;
        ifc.if_valid = 1'b0;
        ifc.id_ready = 1'b0;
        ifc.flush    = 1'b0;
    endtask

    task automatic step(input vec_t t, input int idx);
        rst          = t.rst;
        ifc.if_valid = t.v;
        ifc.if_pc    = t.pc;
        ifc.if_inst  = t.inst;
        ifc.id_ready = t.rdy;
        ifc.flush    = t.fl;
        @(posedge clk);
        #1;
        idle();
        #1;
        check($sformatf("row%0d_valid", idx), 32'(ifc.id_valid),   32'(t.e_valid));
        check($sformatf("row%0d_ready", idx), 32'(ifc.if_ready),   32'(t.e_ready));
        check($sformatf("row%0d_count", idx), 32'(ifc.count),      32'(t.e_cnt));
        check($sformatf("row%0d_pc", idx),    ifc.id_pc,           t.e_pc);
        check($sformatf("row%0d_ctrl", idx),  32'(ifc.id_is_ctrl), 32'(t.e_ctrl));
    endtask

    initial begin
        ifc.if_pc   = 32'h0;
        ifc.if_inst = ADDI;
        idle();
        rst = 1'b1;

        //            rst   v     pc            inst  rdy   fl    valid ready cnt   pc            ctrl
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,  ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,  ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0,  ADDI, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h4,  ADDI, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h8,  ADDI, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'hC,  ADDI, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h10, ADDI, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 32'h4,  1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h8,  1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 32'hC,  1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h10, ADDI, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h10, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h14, ADDI, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'h10, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h18, ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h14, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h1C, ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h18, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h20, ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h1C, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h24, ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h20, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h28, ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h24, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h2C, ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h28, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h30, ADDI, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 32'h28, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h34, ADDI, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h40, JAL,  1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h40, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h44, ADDI, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'h40, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 32'h44, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h48, JALR, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h48, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h4C, BEQ,  1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 32'h4C, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  ADDI, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h50, ADDI, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h50, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 32'h54, ADDI, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0,  1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Empty queue offered a JAL with decode ready: bypass or one-cycle latency.
        @(negedge clk);
        ifc.if_valid = 1'b1; ifc.if_pc = 32'h60; ifc.if_inst = JAL; ifc.id_ready = 1'b1;
        #1;
`ifdef IFQ_BYPASS_EN
        check("byp_valid", 32'(ifc.id_valid), 32'd1);
        check("byp_pc",    ifc.id_pc,         32'h60);
        check("byp_ctrl",  32'(ifc.id_is_ctrl), 32'd1);
        @(posedge clk); #1; idle(); #1;
        check("byp_count", 32'(ifc.count),    32'd0);
        check("byp_after", 32'(ifc.id_valid), 32'd0);
`else
        check("lat_valid", 32'(ifc.id_valid), 32'd0);
        check("lat_pc",    ifc.id_pc,         32'h0);
        @(posedge clk); #1; idle(); #1;
        check("lat_count", 32'(ifc.count),    32'd1);
        check("lat_pc1",   ifc.id_pc,         32'h60);
        check("lat_ctrl",  32'(ifc.id_is_ctrl), 32'd1);
        ifc.id_ready = 1'b1;
        @(posedge clk); #1; idle(); #1;
        check("lat_drain", 32'(ifc.count),    32'd0);
`endif

        // Flush on an empty queue with a live offer: nothing shown, nothing kept.
        @(negedge clk);
        ifc.if_valid = 1'b1; ifc.if_pc = 32'h64; ifc.flush = 1'b1;
        #1;
        check("flush_valid", 32'(ifc.id_valid), 32'd0);
        @(posedge clk); #1; idle(); #1;
        check("flush_count", 32'(ifc.count), 32'd0);

        // Random run against the queue model, starting from a reset.
        model.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 600; n++) begin
            logic r, v, rdy, fl, exp_valid, exp_ctrl;
            logic [31:0] pc, inst, exp_pc, exp_inst;
            ent_t e;
            bit take;
            @(negedge clk);
            r    = ($urandom_range(0, 79) == 0);
            v    = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            pc   = $urandom;
            inst = $urandom;
            case ($urandom_range(0, 5))
                0: inst[6:0] = 7'h6F;
                1: inst[6:0] = 7'h67;
                2: inst[6:0] = 7'h63;
                default: ;
            endcase
            rst = r; ifc.if_valid = v; ifc.if_pc = pc; ifc.if_inst = inst;
            ifc.id_ready = rdy; ifc.flush = fl;
            #1;
            exp_valid = 1'b0; exp_pc = 32'h0; exp_inst = 32'h0; exp_ctrl = 1'b0;
            if (model.size() > 0) begin
                exp_valid = 1'b1; exp_pc = model[0].pc; exp_inst = model[0].inst;
                exp_ctrl = ref_ctrl(model[0].inst);
            end
`ifdef IFQ_BYPASS_EN
            else if (v && !fl) begin
                exp_valid = 1'b1; exp_pc = pc; exp_inst = inst; exp_ctrl = ref_ctrl(inst);
            end
`endif
            check("rnd_valid", 32'(ifc.id_valid),   32'(exp_valid));
            check("rnd_pc",    ifc.id_pc,           exp_pc);
            check("rnd_inst",  ifc.id_inst,         exp_inst);
            check("rnd_ctrl",  32'(ifc.id_is_ctrl), 32'(exp_ctrl));
            check("rnd_ready", 32'(ifc.if_ready),   32'(model.size() != DEPTH));
            check("rnd_count", 32'(ifc.count),      32'(model.size()));
            @(posedge clk);
            if (r || fl) begin
                model.delete();
            end else begin
                take = 1'b0;
`ifdef IFQ_BYPASS_EN
                take = (model.size() == 0) && v && rdy;
`endif
                e.pc = pc; e.inst = inst;
                if (v && model.size() < DEPTH && !take) begin
                    if (model.size() > 0 && rdy) void'(model.pop_front());
                    model.push_back(e);
                end else if (model.size() > 0 && rdy) begin
                    void'(model.pop_front());
                end
            end
        end
        #1;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
